// File: rtl/vigenere_stream_cipher_pkg.sv
// Shared constants, FSM state encoding and character helpers for the Vigenere cipher blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: ASCII bounds, alphabet size, mode encoding, state enum, is_upper() classifier.
package vigenere_pkg;

    localparam logic [7:0] ASCII_A = 8'd65;
    localparam logic [7:0] ASCII_Z = 8'd90;
    localparam logic [4:0] ALPHA_N = 5'd26;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic {
        NOKEY = 1'b0,
        RUN   = 1'b1
    } state_t;

    function automatic logic is_upper(input logic [7:0] c);
        return (c >= ASCII_A) && (c <= ASCII_Z);
    endfunction

endpackage

// File: rtl/vigenere_stream_cipher_if.sv
// Character stream bundle: input side (source -> cipher) and output side (cipher -> sink).
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both sides; a beat moves when valid and ready are both high.
// Modports: slave = cipher block, master = character source/sink (testbench, UART glue).
interface vigenere_stream_cipher_if;

    logic       inValid;
    logic [7:0] inChar;
    logic       inReady;
    logic       outValid;
    logic [7:0] outChar;
    logic       outReady;

    modport slave (
        input  inValid,
        input  inChar,
        input  outReady,
        output inReady,
        output outValid,
        output outChar
    );

    modport master (
        output inValid,
        output inChar,
        output outReady,
        input  inReady,
        input  outValid,
        input  outChar
    );

endinterface

// File: rtl/vigenere_char_shift.sv
// Single-character Vigenere shift: uppercase letters rotate by the key letter, others pass through.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
// Ports: char_in, key_char (assumed uppercase), mode (0 enc / 1 dec) -> char_out, is_letter.
module vigenere_char_shift
    import vigenere_pkg::*;
(
    input  logic [7:0] char_in,
    input  logic [7:0] key_char,
    input  logic       mode,
    output logic [7:0] char_out,
    output logic       is_letter
);

    logic [7:0] p;
    logic [7:0] k;
    logic [7:0] alpha_n8;
    logic [7:0] sum;
    logic [7:0] enc;
    logic [7:0] dec;
    logic [7:0] shifted;

    assign alpha_n8  = {3'b000, ALPHA_N};
    assign is_letter = is_upper(char_in);

    // Offsets within the alphabet, 0..25 when the inputs are letters.
    assign p = char_in - ASCII_A;
    assign k = key_char - ASCII_A;

    // Encrypt: a single conditional subtract is enough since p+k <= 50.
    assign sum = p + k;
    assign enc = (sum >= alpha_n8) ? (sum - alpha_n8) : sum;

    // Decrypt: add the modulus before subtracting so the result never goes negative.
    assign dec = (p >= k) ? (p - k) : (p + alpha_n8 - k);

    assign shifted  = ((mode == MODE_DEC) ? dec : enc) + ASCII_A;
    assign char_out = is_letter ? shifted : char_in;

endmodule

// File: rtl/vigenere_stream_cipher.sv
// Streaming Vigenere engine: parallel-loaded multi-char key, key pointer advances per accepted letter.
// Latency: 1 cycle from accept to outValid; 1 char/cycle when the sink drains every cycle.
// Backpressure: inReady drops while a result is held unconsumed (outReady=0) or during LOAD.
// Ports: CLK, RST_N (sync, active-low), LOAD/keyInput/keyLen/MODE controls, stream (slave modport),
//        keyErr (last LOAD rejected), keyIdx (key char used for the next letter).
module vigenere_stream_cipher
    import vigenere_pkg::*;
#(
    parameter int KEY_CHARS = 10,
    parameter int LEN_W     = $clog2(KEY_CHARS + 1)
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   LOAD,
    input  logic [8*KEY_CHARS-1:0] keyInput,
    input  logic [LEN_W-1:0]       keyLen,
    input  logic                   MODE,
    vigenere_stream_cipher_if.slave stream,
    output logic                   keyErr,
    output logic [LEN_W-1:0]       keyIdx
);

    state_t                 state_q;
    state_t                 state_d;

    logic [8*KEY_CHARS-1:0] key_q;
    logic [LEN_W-1:0]       key_len_q;
    logic [LEN_W-1:0]       key_idx_q;
    logic                   key_err_q;
    logic                   out_vld_q;
    logic [7:0]             out_chr_q;

    logic                   len_ok;
    logic                   chars_ok;
    logic                   key_ok;
    logic                   in_rdy;
    logic                   accept;
    logic [7:0]             key_char;
    logic [7:0]             res_char;
    logic                   res_letter;
    logic                   idx_wrap;

    // Key validation: only the first keyLen characters are inspected.
    assign len_ok = (keyLen != '0) && (int'(keyLen) <= KEY_CHARS);

    always_comb begin
        chars_ok = 1'b1;
        for (int i = 0; i < KEY_CHARS; i++) begin
            if ((i < int'(keyLen)) && !is_upper(keyInput[8*i +: 8])) begin
                chars_ok = 1'b0;
            end
        end
    end

    assign key_ok = len_ok && chars_ok;

    // FSM: a LOAD decides the state outright, valid or not.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= NOKEY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (LOAD) begin
            state_d = key_ok ? RUN : NOKEY;
        end
    end

    // Accept only when the output register is empty or emptying on this edge.
    assign in_rdy = (state_q == RUN) && !LOAD && (!out_vld_q || stream.outReady);
    assign accept = stream.inValid && in_rdy;

    // Key character mux by compare so an out-of-range pointer value just yields zero.
    always_comb begin
        key_char = '0;
        for (int i = 0; i < KEY_CHARS; i++) begin
            if (key_idx_q == LEN_W'(i)) begin
                key_char = key_q[8*i +: 8];
            end
        end
    end

    vigenere_char_shift u_shift (
        .char_in   (stream.inChar),
        .key_char  (key_char),
        .mode      (MODE),
        .char_out  (res_char),
        .is_letter (res_letter)
    );

    assign idx_wrap = (key_idx_q == (key_len_q - LEN_W'(1)));

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            key_q     <= '0;
            key_len_q <= '0;
            key_idx_q <= '0;
            key_err_q <= 1'b0;
            out_vld_q <= 1'b0;
            out_chr_q <= 8'h00;
        end else if (LOAD) begin
            // Any pending result belongs to the old key and is dropped.
            out_vld_q <= 1'b0;
            key_idx_q <= '0;
            if (key_ok) begin
                key_q     <= keyInput;
                key_len_q <= keyLen;
                key_err_q <= 1'b0;
            end else begin
                key_err_q <= 1'b1;
            end
        end else if (accept) begin
            out_vld_q <= 1'b1;
            out_chr_q <= res_char;
            if (res_letter) begin
                key_idx_q <= idx_wrap ? '0 : (key_idx_q + LEN_W'(1));
            end
        end else if (stream.outReady) begin
            out_vld_q <= 1'b0;
        end
    end

    assign stream.inReady  = in_rdy;
    assign stream.outValid = out_vld_q;
    assign stream.outChar  = out_chr_q;
    assign keyErr          = key_err_q;
    assign keyIdx          = key_idx_q;

endmodule

// File: tb/tb_vigenere_stream_cipher.sv
// Directed bench for vigenere_stream_cipher: known Vigenere vectors, key validation, backpressure, reset.
// Latency: expects results one cycle after accept.
// Backpressure: drives outReady low to hold results and checks inReady/keyIdx freeze.
module tb_vigenere_stream_cipher;

    localparam int KEY_CHARS = 10;
    localparam int LEN_W     = $clog2(KEY_CHARS + 1);

    logic                   clk;
    logic                   rst_n;
    logic                   load;
    logic [8*KEY_CHARS-1:0] key_input;
    logic [LEN_W-1:0]       key_len;
    logic                   mode;
    logic                   key_err;
    logic [LEN_W-1:0]       key_idx;

    int n_vec;
    int n_err;

    vigenere_stream_cipher_if stream ();

    vigenere_stream_cipher #(
        .KEY_CHARS (KEY_CHARS),
        .LEN_W     (LEN_W)
    ) dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .LOAD     (load),
        .keyInput (key_input),
        .keyLen   (key_len),
        .MODE     (mode),
        .stream   (stream),
        .keyErr   (key_err),
        .keyIdx   (key_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input string k, input int len, input bit exp_ok);
        key_input = '0;
        for (int i = 0; i < k.len() && i < KEY_CHARS; i++) begin
            key_input[8*i +: 8] = k[i];
        end
        key_len = LEN_W'(len);
        load    = 1'b1;
        #1;
        check_vec("inready_during_load", 32'(stream.inReady), 32'd0);
        tick();
        load = 1'b0;
        #1;
        check_vec({"keyerr_", k}, 32'(key_err), 32'(!exp_ok));
        check_vec({"inready_after_load_", k}, 32'(stream.inReady), 32'(exp_ok));
        check_vec("keyidx_after_load", 32'(key_idx), 32'd0);
        check_vec("outvalid_after_load", 32'(stream.outValid), 32'd0);
    endtask

    // Streams pt with outReady=1; key pointer assumed at 0 (fresh LOAD).
    task automatic send_str(input string pt, input string ct, input int len);
        int  exp_idx;
        byte c;
        exp_idx = 0;
        stream.outReady = 1'b1;
        for (int i = 0; i < pt.len(); i++) begin
            c = pt[i];
            check_vec("keyidx_before", 32'(key_idx), 32'(exp_idx));
            check_vec("inready_stream", 32'(stream.inReady), 32'd1);
            stream.inValid = 1'b1;
            stream.inChar  = c;
            tick();
            check_vec("outvalid_stream", 32'(stream.outValid), 32'd1);
            check_vec({"outchar_", pt}, 32'(stream.outChar), 32'(ct[i]));
            if (c >= 8'd65 && c <= 8'd90) begin
                exp_idx = (exp_idx + 1) % len;
            end
        end
        check_vec("keyidx_end", 32'(key_idx), 32'(exp_idx));
        stream.inValid = 1'b0;
        tick();
        check_vec("outvalid_drained", 32'(stream.outValid), 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        load = 1'b0;
        key_input = '0;
        key_len = '0;
        mode = 1'b0;
        stream.inValid = 1'b0;
        stream.inChar = 8'h00;
        stream.outReady = 1'b1;

        // Reset state
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check_vec("rst_outvalid", 32'(stream.outValid), 32'd0);
        check_vec("rst_outchar", 32'(stream.outChar), 32'd0);
        check_vec("rst_keyerr", 32'(key_err), 32'd0);
        check_vec("rst_keyidx", 32'(key_idx), 32'd0);
        check_vec("rst_inready", 32'(stream.inReady), 32'd0);

        // Classic vector, encrypt then decrypt
        mode = 1'b0;
        load_key("LEMON", 5, 1'b1);
        send_str("ATTACKATDAWN", "LXFOPVEFRNHR", 5);
        mode = 1'b1;
        load_key("LEMON", 5, 1'b1);
        send_str("LXFOPVEFRNHR", "ATTACKATDAWN", 5);

        // Single-char key, decrypt wraps below zero
        load_key("Z", 1, 1'b1);
        send_str("AA", "BB", 1);

        // Space passes through without advancing the key
        mode = 1'b0;
        load_key("LEMON", 5, 1'b1);
        send_str("AT TACK", "LX FOPV", 5);

        // Backpressure
        load_key("LEMON", 5, 1'b1);
        stream.outReady = 1'b0;
        stream.inValid  = 1'b1;
        stream.inChar   = "A";
        tick();
        stream.inChar = "T";
        for (int i = 0; i < 3; i++) begin
            check_vec("bp_outvalid", 32'(stream.outValid), 32'd1);
            check_vec("bp_outchar", 32'(stream.outChar), 32'("L"));
            check_vec("bp_inready", 32'(stream.inReady), 32'd0);
            check_vec("bp_keyidx", 32'(key_idx), 32'd1);
            tick();
        end
        stream.outReady = 1'b1;
        #1;
        check_vec("bp_release_inready", 32'(stream.inReady), 32'd1);
        tick();
        check_vec("bp_resume_1", 32'(stream.outChar), 32'("X"));
        stream.inChar = "T";
        tick();
        check_vec("bp_resume_2", 32'(stream.outChar), 32'("F"));
        check_vec("bp_resume_idx", 32'(key_idx), 32'd3);
        stream.inValid = 1'b0;
        tick();
        check_vec("bp_drained", 32'(stream.outValid), 32'd0);

        // Key validation
        load_key("LEMON", 0, 1'b0);
        load_key("LEMON", 5, 1'b1);
        load_key("LaMON", 5, 1'b0);
        load_key("ABCDa", 4, 1'b1);
        load_key("ABCDEFGHIJ", 11, 1'b0);
        load_key("ABCDEFGHIJ", 10, 1'b1);
        send_str("AAAAAAAAAAAB", "ABCDEFGHIJAC", 10);

        // Reset mid-stream with a held result
        load_key("LEMON", 5, 1'b1);
        stream.outReady = 1'b0;
        stream.inValid  = 1'b1;
        stream.inChar   = "A";
        tick();
        stream.inValid = 1'b0;
        check_vec("mid_outvalid_pre", 32'(stream.outValid), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check_vec("mid_rst_outvalid", 32'(stream.outValid), 32'd0);
        check_vec("mid_rst_outchar", 32'(stream.outChar), 32'd0);
        check_vec("mid_rst_inready", 32'(stream.inReady), 32'd0);
        stream.outReady = 1'b1;
        stream.inValid  = 1'b1;
        stream.inChar   = "A";
        tick();
        check_vec("nokey_no_accept", 32'(stream.outValid), 32'd0);

        // LOAD with inValid in the same cycle: char must not be taken
        load = 1'b1;
        key_input = '0;
        key_input[39:0] = {"N", "O", "M", "E", "L"};
        key_len = LEN_W'(5);
        #1;
        check_vec("load_inready", 32'(stream.inReady), 32'd0);
        tick();
        load = 1'b0;
        stream.inValid = 1'b0;
        #1;
        check_vec("load_same_cycle_outvalid", 32'(stream.outValid), 32'd0);
        check_vec("load_same_cycle_keyidx", 32'(key_idx), 32'd0);
        send_str("A", "L", 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
